// File: rtl/ring_node_q.sv
// ring_node_q
//   One node of the force-distribution ring. Transit packets are forwarded to
//   the next node, packets addressed to this node are ejected to the local
//   force cache, and packets from the local PE wait in a small queue until
//   an output slot is free. If the queue is held off by ring traffic for
//   too long, throttle_out asks the upstream neighbour to stop injecting.
//
//   Packet format: {dest_id[ID_W-1:0], payload[DATA_W-1:0]}
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   pe_pkt_in       packet from the local PE; pe_pkt_valid qualifies it
//   pe_ready        queue can accept a packet this cycle (not full)
//   prev_pkt_in     packet from the upstream node; prev_pkt_valid qualifies it
//   throttle_in     downstream node is starving; hold off local injection
//   nxt_pkt_out     registered packet to the downstream node (+ nxt_pkt_valid)
//   fc_data_out     registered payload to the force cache (+ fc_data_valid)
//   throttle_out    registered: this node is starving
//   q_count         current queue occupancy, 0..FIFO_DEPTH
//   err_drop        one-cycle pulse after a PE packet with an invalid dest

module ring_node_q #(
   parameter int NUM_CELLS    = 8,
   parameter int HOME_CELL_ID = 0,
   parameter int DATA_W       = 96,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8,
   localparam int ID_W  = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1,
   localparam int PKT_W = ID_W + DATA_W,
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PKT_W-1:0]  pe_pkt_in,
   input  logic              pe_pkt_valid,
   output logic              pe_ready,
   input  logic [PKT_W-1:0]  prev_pkt_in,
   input  logic              prev_pkt_valid,
   input  logic              throttle_in,
   output logic [PKT_W-1:0]  nxt_pkt_out,
   output logic              nxt_pkt_valid,
   output logic [DATA_W-1:0] fc_data_out,
   output logic              fc_data_valid,
   output logic              throttle_out,
   output logic [CNT_W-1:0]  q_count,
   output logic              err_drop
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   localparam logic [ID_W-1:0]  HOME_V  = ID_W'(HOME_CELL_ID);
   localparam logic [ID_W:0]    CELLS_V = (ID_W + 1)'(NUM_CELLS);
   localparam logic [CNT_W-1:0] DEPTH_V = CNT_W'(FIFO_DEPTH);
   localparam logic [SC_W:0]    LIM_V   = (SC_W + 1)'(STARVE_LIMIT);
   localparam bit               THR_EN  = (STARVE_LIMIT != 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_STARVE = 2'd2
   } starve_state_t;

   // Injection queue
   logic [PKT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic             full;
   logic             empty;
   logic             push_req;
   logic             bad_dest;
   logic             push;
   logic             pop;

   // Ring / head decode
   logic [ID_W-1:0]  prev_dest;
   logic [ID_W-1:0]  pe_dest;
   logic [PKT_W-1:0] head;
   logic [ID_W-1:0]  head_dest;
   logic             head_home;
   logic             ring_eject;
   logic             ring_fwd;
   logic             port_free;
   logic             ring_blocked;

   // Starvation tracking
   starve_state_t    state;
   logic [SC_W-1:0]  starve_cnt;
   logic [SC_W:0]    cnt_inc;

   assign prev_dest  = prev_pkt_in[PKT_W-1:DATA_W];
   assign pe_dest    = pe_pkt_in[PKT_W-1:DATA_W];
   assign head       = mem[rd_ptr];
   assign head_dest  = head[PKT_W-1:DATA_W];
   assign head_home  = (head_dest == HOME_V);

   assign ring_eject = prev_pkt_valid && (prev_dest == HOME_V);
   assign ring_fwd   = prev_pkt_valid && (prev_dest != HOME_V);

   assign full       = (count == DEPTH_V);
   assign empty      = (count == '0);
   // No push-through: a full queue refuses even when it pops this cycle.
   assign pe_ready   = !full;
   assign q_count    = count;

   assign push_req   = pe_pkt_valid && pe_ready;
   assign bad_dest   = ({1'b0, pe_dest} >= CELLS_V);
   assign push       = push_req && !bad_dest;

   // A self-send competes with ring ejection for the force-cache port;
   // any other head competes with ring forwarding for the downstream slot.
   assign port_free    = head_home ? !ring_eject : !ring_fwd;
   assign pop          = !empty && !throttle_in && port_free;
   assign ring_blocked = !empty && !port_free;

   assign cnt_inc      = {1'b0, starve_cnt} + (SC_W + 1)'(1);

   // Queue storage: contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= pe_pkt_in;
      end
   end

   // Queue pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Output registers: ring traffic first, queue head fills a free port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nxt_pkt_out   <= '0;
         nxt_pkt_valid <= 1'b0;
         fc_data_out   <= '0;
         fc_data_valid <= 1'b0;
         err_drop      <= 1'b0;
      end else begin
         err_drop <= push_req && bad_dest;

         if (ring_fwd) begin
            nxt_pkt_out   <= prev_pkt_in;
            nxt_pkt_valid <= 1'b1;
         end else if (pop && !head_home) begin
            nxt_pkt_out   <= head;
            nxt_pkt_valid <= 1'b1;
         end else begin
            nxt_pkt_valid <= 1'b0;
         end

         if (ring_eject) begin
            fc_data_out   <= prev_pkt_in[DATA_W-1:0];
            fc_data_valid <= 1'b1;
         end else if (pop && head_home) begin
            fc_data_out   <= head[DATA_W-1:0];
            fc_data_valid <= 1'b1;
         end else begin
            fc_data_valid <= 1'b0;
         end
      end
   end

   // Starvation FSM. Only ring occupancy counts as starvation; being held
   // off by throttle_in alone leaves the count where it is.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         starve_cnt   <= '0;
         throttle_out <= 1'b0;
      end else if (!THR_EN) begin
         state        <= S_IDLE;
         starve_cnt   <= '0;
         throttle_out <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ring_blocked) begin
                  if (LIM_V <= (SC_W + 1)'(1)) begin
                     state        <= S_STARVE;
                     throttle_out <= 1'b1;
                  end else begin
                     state      <= S_WAIT;
                     starve_cnt <= SC_W'(1);
                  end
               end
            end
            S_WAIT: begin
               if (pop || empty) begin
                  state      <= S_IDLE;
                  starve_cnt <= '0;
               end else if (ring_blocked) begin
                  if (cnt_inc >= LIM_V) begin
                     state        <= S_STARVE;
                     throttle_out <= 1'b1;
                  end else begin
                     starve_cnt <= cnt_inc[SC_W-1:0];
                  end
               end
            end
            S_STARVE: begin
               if (pop || empty) begin
                  state        <= S_IDLE;
                  starve_cnt   <= '0;
                  throttle_out <= 1'b0;
               end
            end
            default: begin
               state        <= S_IDLE;
               starve_cnt   <= '0;
               throttle_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ring_node_q.sv
// tb_ring_node_q
//   Directed bench for ring_node_q configured as node 2 of a 6-node ring
//   (3-bit ids, so dest 7 is an invalid destination), 16-bit payloads,
//   4-deep queue, starvation limit 8.

module tb_ring_node_q;

   localparam int NUM_CELLS    = 6;
   localparam int HOME_CELL_ID = 2;
   localparam int DATA_W       = 16;
   localparam int FIFO_DEPTH   = 4;
   localparam int STARVE_LIMIT = 8;
   localparam int ID_W         = 3;
   localparam int PKT_W        = ID_W + DATA_W;
   localparam int CNT_W        = 3;
   localparam int NVEC         = 20;

   logic              clk = 1'b0;
   logic              rst;
   logic [PKT_W-1:0]  pe_pkt_in;
   logic              pe_pkt_valid;
   logic              pe_ready;
   logic [PKT_W-1:0]  prev_pkt_in;
   logic              prev_pkt_valid;
   logic              throttle_in;
   logic [PKT_W-1:0]  nxt_pkt_out;
   logic              nxt_pkt_valid;
   logic [DATA_W-1:0] fc_data_out;
   logic              fc_data_valid;
   logic              throttle_out;
   logic [CNT_W-1:0]  q_count;
   logic              err_drop;

   int n_tests = 0;
   int n_fail  = 0;

   ring_node_q #(
      .NUM_CELLS    (NUM_CELLS),
      .HOME_CELL_ID (HOME_CELL_ID),
      .DATA_W       (DATA_W),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pe_pkt_in      (pe_pkt_in),
      .pe_pkt_valid   (pe_pkt_valid),
      .pe_ready       (pe_ready),
      .prev_pkt_in    (prev_pkt_in),
      .prev_pkt_valid (prev_pkt_valid),
      .throttle_in    (throttle_in),
      .nxt_pkt_out    (nxt_pkt_out),
      .nxt_pkt_valid  (nxt_pkt_valid),
      .fc_data_out    (fc_data_out),
      .fc_data_valid  (fc_data_valid),
      .throttle_out   (throttle_out),
      .q_count        (q_count),
      .err_drop       (err_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              pv;
      logic [PKT_W-1:0]  pp;
      logic              ev;
      logic [PKT_W-1:0]  ep;
      logic              thr;
      logic              e_nv;
      logic [PKT_W-1:0]  e_np;
      logic              e_fv;
      logic [DATA_W-1:0] e_fd;
      logic [CNT_W-1:0]  e_q;
      logic              e_err;
   } vec_t;

   vec_t vec [NVEC];

   function automatic logic [PKT_W-1:0] pkt(input int d, input logic [DATA_W-1:0] p);
      logic [ID_W-1:0] dd;
      dd = ID_W'(d);
      return {dd, p};
   endfunction

   function automatic vec_t mk(input logic pv, input logic [PKT_W-1:0] pp,
                               input logic ev, input logic [PKT_W-1:0] ep,
                               input logic thr,
                               input logic e_nv, input logic [PKT_W-1:0] e_np,
                               input logic e_fv, input logic [DATA_W-1:0] e_fd,
                               input int e_q, input logic e_err);
      vec_t v;
      v.pv = pv;   v.pp = pp;   v.ev = ev;     v.ep = ep;     v.thr = thr;
      v.e_nv = e_nv; v.e_np = e_np; v.e_fv = e_fv; v.e_fd = e_fd;
      v.e_q = CNT_W'(e_q); v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic [PKT_W-1:0] pp,
                        input logic ev, input logic [PKT_W-1:0] ep, input logic thr);
      prev_pkt_valid = pv;
      prev_pkt_in    = pp;
      pe_pkt_valid   = ev;
      pe_pkt_in      = ep;
      throttle_in    = thr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [PKT_W-1:0] z;

   initial begin
      z = '0;
      // idx: prev(v,pkt) | pe(v,pkt) | thr || exp nxt(v,pkt) | fc(v,data) | q | err
      vec[0]  = mk(1, pkt(5,16'h1111), 0, z, 0,  1, pkt(5,16'h1111), 0, 16'h0000, 0, 0); // forward
      vec[1]  = mk(1, pkt(2,16'h2222), 0, z, 0,  0, pkt(5,16'h1111), 1, 16'h2222, 0, 0); // eject
      vec[2]  = mk(0, z, 0, z, 0,                0, pkt(5,16'h1111), 0, 16'h2222, 0, 0); // idle, hold
      vec[3]  = mk(0, z, 1, pkt(4,16'h4444), 0,  0, pkt(5,16'h1111), 0, 16'h2222, 1, 0); // push
      vec[4]  = mk(0, z, 0, z, 0,                1, pkt(4,16'h4444), 0, 16'h2222, 0, 0); // pop -> nxt
      vec[5]  = mk(1, pkt(3,16'h3333), 1, pkt(4,16'h5555), 0,
                                                 1, pkt(3,16'h3333), 0, 16'h2222, 1, 0);
      vec[6]  = mk(1, pkt(2,16'h6666), 0, z, 0,  1, pkt(4,16'h5555), 1, 16'h6666, 0, 0); // eject+inject
      vec[7]  = mk(0, z, 1, pkt(2,16'h7777), 0,  0, pkt(4,16'h5555), 0, 16'h6666, 1, 0); // self-send push
      vec[8]  = mk(0, z, 0, z, 0,                0, pkt(4,16'h5555), 1, 16'h7777, 0, 0); // self-send out
      vec[9]  = mk(0, z, 1, pkt(2,16'h8888), 0,  0, pkt(4,16'h5555), 0, 16'h7777, 1, 0);
      vec[10] = mk(1, pkt(2,16'h9999), 0, z, 0,  0, pkt(4,16'h5555), 1, 16'h9999, 1, 0); // self blocked by eject
      vec[11] = mk(1, pkt(0,16'hAAAA), 0, z, 0,  1, pkt(0,16'hAAAA), 1, 16'h8888, 0, 0); // fwd + self-send
      vec[12] = mk(0, z, 1, pkt(7,16'hBBBB), 0,  0, pkt(0,16'hAAAA), 0, 16'h8888, 0, 1); // bad dest
      vec[13] = mk(0, z, 0, z, 0,                0, pkt(0,16'hAAAA), 0, 16'h8888, 0, 0);
      vec[14] = mk(0, z, 1, pkt(1,16'hCCCC), 1,  0, pkt(0,16'hAAAA), 0, 16'h8888, 1, 0); // throttled
      vec[15] = mk(0, z, 0, z, 1,                0, pkt(0,16'hAAAA), 0, 16'h8888, 1, 0);
      vec[16] = mk(0, z, 0, z, 0,                1, pkt(1,16'hCCCC), 0, 16'h8888, 0, 0);
      vec[17] = mk(0, z, 1, pkt(5,16'hDDDD), 0,  0, pkt(1,16'hCCCC), 0, 16'h8888, 1, 0);
      vec[18] = mk(0, z, 1, pkt(5,16'hEEEE), 0,  1, pkt(5,16'hDDDD), 0, 16'h8888, 1, 0); // push+pop
      vec[19] = mk(0, z, 0, z, 0,                1, pkt(5,16'hEEEE), 0, 16'h8888, 0, 0);

      // Reset state
      rst = 1'b1;
      drive(0, z, 0, z, 0);
      #2;
      chk("reset_nxt_valid", nxt_pkt_valid, 0);
      chk("reset_fc_valid", fc_data_valid, 0);
      chk("reset_q_count", q_count, 0);
      chk("reset_pe_ready", pe_ready, 1);
      chk("reset_throttle", throttle_out, 0);
      chk("reset_nxt_data", nxt_pkt_out, 0);
      tick();
      tick();
      rst = 1'b0;

      // Table-driven single-cycle behaviour
      for (int i = 0; i < NVEC; i++) begin
         drive(vec[i].pv, vec[i].pp, vec[i].ev, vec[i].ep, vec[i].thr);
         tick();
         chk($sformatf("vec%0d_nxt_valid", i), nxt_pkt_valid, vec[i].e_nv);
         chk($sformatf("vec%0d_nxt_pkt", i), nxt_pkt_out, vec[i].e_np);
         chk($sformatf("vec%0d_fc_valid", i), fc_data_valid, vec[i].e_fv);
         chk($sformatf("vec%0d_fc_data", i), fc_data_out, vec[i].e_fd);
         chk($sformatf("vec%0d_q_count", i), q_count, vec[i].e_q);
         chk($sformatf("vec%0d_err_drop", i), err_drop, vec[i].e_err);
         chk($sformatf("vec%0d_pe_ready", i), pe_ready, 1);
         chk($sformatf("vec%0d_throttle", i), throttle_out, 0);
      end

      // Saturated ring: fill queue, overflow attempt, starvation
      for (int c = 0; c < 10; c++) begin
         drive(1, pkt(5, 16'hF000 + 16'(c)), (c <= 4), pkt(4, 16'h0A00 + 16'(c)), 0);
         tick();
         chk($sformatf("sat%0d_nxt_valid", c), nxt_pkt_valid, 1);
         chk($sformatf("sat%0d_nxt_pkt", c), nxt_pkt_out, pkt(5, 16'hF000 + 16'(c)));
         chk($sformatf("sat%0d_q_count", c), q_count, (c < 4) ? c + 1 : 4);
         chk($sformatf("sat%0d_pe_ready", c), pe_ready, (c < 3) ? 1 : 0);
         chk($sformatf("sat%0d_throttle", c), throttle_out, (c >= 8) ? 1 : 0);
      end
      // Slot frees: drain the four queued packets; the fifth was never taken
      for (int c = 0; c < 5; c++) begin
         drive(0, z, 0, z, 0);
         tick();
         chk($sformatf("drain%0d_nxt_valid", c), nxt_pkt_valid, (c < 4) ? 1 : 0);
         if (c < 4) begin
            chk($sformatf("drain%0d_nxt_pkt", c), nxt_pkt_out, pkt(4, 16'h0A00 + 16'(c)));
         end
         chk($sformatf("drain%0d_q_count", c), q_count, (c < 4) ? 3 - c : 0);
         chk($sformatf("drain%0d_pe_ready", c), pe_ready, 1);
         chk($sformatf("drain%0d_throttle", c), throttle_out, 0);
      end

      // Asynchronous reset mid-operation
      for (int c = 0; c < 3; c++) begin
         drive(1, pkt(5, 16'hF100 + 16'(c)), 1, pkt(4, 16'hA001 + 16'(c)), 0);
         tick();
      end
      chk("pre_rst_q_count", q_count, 3);
      chk("pre_rst_nxt_valid", nxt_pkt_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_nxt_valid", nxt_pkt_valid, 0);
      chk("async_rst_fc_valid", fc_data_valid, 0);
      chk("async_rst_q_count", q_count, 0);
      chk("async_rst_pe_ready", pe_ready, 1);
      chk("async_rst_throttle", throttle_out, 0);
      drive(0, z, 0, z, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_nxt_valid", nxt_pkt_valid, 0);
      chk("post_rst_fc_valid", fc_data_valid, 0);
      chk("post_rst_q_count", q_count, 0);
      drive(0, z, 1, pkt(4, 16'h5A5A), 0);
      tick();
      chk("post_rst_push_q", q_count, 1);
      drive(0, z, 0, z, 0);
      tick();
      chk("post_rst_pop_valid", nxt_pkt_valid, 1);
      chk("post_rst_pop_pkt", nxt_pkt_out, pkt(4, 16'h5A5A));
      chk("post_rst_pop_q", q_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
